// File: rtl/conbus_pkg.sv
// conbus_pkg: shared Wishbone widths, cycle-type codes and index helper for the conbus_xn interconnect.
package conbus_pkg;
    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_e;
    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        onehot2idx = '0;
        for (int i = 0; i < 16; i++)
            if (oh[i]) onehot2idx = 4'(i);
    endfunction
endpackage

// File: rtl/conbus_xn_if.sv
// conbus_xn_if: bundle of all master-side and slave-side bus signals of the shared interconnect.
interface conbus_xn_if #(
    parameter int NM = 3,
    parameter int NS = 7
);
    import conbus_pkg::*;
    logic [NM*WB_DW-1:0] m_dat_i;
    logic [NM*WB_AW-1:0] m_adr_i;
    logic [NM*3-1:0]     m_cti_i;
    logic [NM*4-1:0]     m_sel_i;
    logic [NM-1:0]       m_we_i, m_cyc_i, m_stb_i;
    logic [WB_DW-1:0]    m_dat_o;
    logic [NM-1:0]       m_ack_o, m_err_o;
    logic [NS*WB_DW-1:0] s_dat_i;
    logic [NS-1:0]       s_ack_i;
    logic [WB_DW-1:0]    s_dat_o;
    logic [WB_AW-1:0]    s_adr_o;
    logic [2:0]          s_cti_o;
    logic [3:0]          s_sel_o;
    logic                s_we_o;
    logic [NS-1:0]       s_cyc_o, s_stb_o;
    modport con (
        input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
    modport master (
        output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o
    );
    modport slave (
        input  s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/conbus_rr_arb.sv
// conbus_rr_arb: round-robin arbiter; the grant is locked while its owner keeps cyc high.
module conbus_rr_arb
    import conbus_pkg::*;
#(
    parameter int NM = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [NM-1:0] req,
    output logic [NM-1:0] gnt
);
    localparam int IW = NM > 1 ? $clog2(NM) : 1;
    logic [NM-1:0] r_gnt, w_pick;
    logic [IW-1:0] r_last;
    // Scan downwards so the requester right after r_last is the one left standing.
    always_comb begin
        w_pick = '0;
        for (int k = NM; k >= 1; k--)
            if (req[IW'((int'(r_last) + k) % NM)]) begin
                w_pick = '0;
                w_pick[IW'((int'(r_last) + k) % NM)] = 1'b1;
            end
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_gnt  <= '0;
            r_last <= IW'(NM - 1);
        end else if (~|(r_gnt & req)) begin
            r_gnt <= w_pick;
            if (|req) r_last <= IW'(onehot2idx(16'(w_pick)));
        end
    end
    assign gnt = r_gnt;
endmodule

// File: rtl/conbus_xn.sv
// conbus_xn: NM-master / NS-slave shared Wishbone bus with round-robin arbitration,
// address decode, unmapped-address error and per-beat ack watchdog.
module conbus_xn
    import conbus_pkg::*;
#(
    parameter int                     NM       = 3,
    parameter int                     NS       = 7,
    parameter int                     S_ADDR_W = 3,
    parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = {3'h6, 3'h5, 3'h4, 3'h3, 3'h2, 3'h1, 3'h0},
    parameter int                     TIMEOUT  = 255,
    parameter int                     TO_W     = 8
) (
    input logic         sys_clk,
    input logic         sys_rst,
    conbus_xn_if.con    bus
);
    logic [NM-1:0]    w_gnt;
    logic [WB_AW-1:0] w_adr;
    logic [WB_DW-1:0] w_dat, w_rdat;
    logic [2:0]       w_cti;
    logic [3:0]       w_sel;
    logic             w_we, w_cyc, w_stb, w_sack, w_fire;
    logic [NS-1:0]    w_hit, w_ssel;
    logic             r_err;
    logic [TO_W-1:0]  r_cnt;

    conbus_rr_arb #(.NM(NM)) u_arb (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .req    (bus.m_cyc_i),
        .gnt    (w_gnt)
    );

    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_cti = '0;
        w_sel = '0;
        for (int j = 0; j < NM; j++) begin
            w_adr |= bus.m_adr_i[j*WB_AW +: WB_AW] & {WB_AW{w_gnt[j]}};
            w_dat |= bus.m_dat_i[j*WB_DW +: WB_DW] & {WB_DW{w_gnt[j]}};
            w_cti |= bus.m_cti_i[j*3 +: 3] & {3{w_gnt[j]}};
            w_sel |= bus.m_sel_i[j*4 +: 4] & {4{w_gnt[j]}};
        end
    end
    assign w_we  = |(w_gnt & bus.m_we_i);
    assign w_cyc = |(w_gnt & bus.m_cyc_i);
    assign w_stb = |(w_gnt & bus.m_stb_i);

    // Overlapping match values resolve to the lowest slave index.
    always_comb begin
        w_hit  = '0;
        w_rdat = '0;
        for (int i = 0; i < NS; i++)
            w_hit[i] = w_adr[WB_AW-1 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W];
        w_ssel = w_cyc ? (w_hit & (~w_hit + NS'(1))) : '0;
        for (int i = 0; i < NS; i++)
            w_rdat |= bus.s_dat_i[i*WB_DW +: WB_DW] & {WB_DW{w_ssel[i]}};
    end
    assign w_sack = |(bus.s_ack_i & w_ssel);
    assign w_fire = (TIMEOUT != 0) && (r_cnt == TO_W'(TIMEOUT));

    assign bus.s_adr_o = w_adr;
    assign bus.s_dat_o = w_dat;
    assign bus.s_cti_o = w_cti;
    assign bus.s_sel_o = w_sel;
    assign bus.s_we_o  = w_we;
    assign bus.s_cyc_o = w_ssel;
    assign bus.s_stb_o = w_ssel & {NS{w_stb & ~w_fire}};
    assign bus.m_dat_o = w_rdat;
    assign bus.m_ack_o = w_gnt & {NM{w_sack & ~w_fire}};
    assign bus.m_err_o = w_gnt & {NM{r_err | w_fire}};

    // A grant only moves after its owner drops cyc, so clearing on idle also covers owner changes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_err <= w_cyc & w_stb & ~|w_hit & ~r_err;
            r_cnt <= (TIMEOUT != 0 && w_stb && |w_ssel && !w_sack && !w_fire) ? r_cnt + TO_W'(1) : '0;
        end
    end
endmodule

// File: tb/tb_conbus_xn.sv
// tb_conbus_xn: directed scenarios plus randomized traffic, every cycle checked against a
// transaction-level model of owner, round-robin pointer, watchdog count and error pulse.
module tb_conbus_xn;
    import conbus_pkg::*;
    localparam int NM = 3, NS = 7, TIMEOUT = 16;
    localparam logic [NM-1:0] M1 = 1;
    localparam logic [NS-1:0] S1 = 1;

    logic sys_clk = 0, sys_rst = 1;
    int n_pass = 0, n_chk = 0;
    int own = -1, last = NM - 1, cnt = 0;
    bit err = 0;
    logic [NM-1:0] e_ack = '0, e_err = '0;

    conbus_xn_if #(.NM(NM), .NS(NS)) bus ();
    conbus_xn #(.NM(NM), .NS(NS), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drv(input int j, input bit cyc, input bit stb, input logic [31:0] adr,
                       input logic [2:0] cti = CLASSIC);
        bus.m_cyc_i[j] = cyc;
        bus.m_stb_i[j] = stb;
        bus.m_adr_i[j*32 +: 32] = adr;
        bus.m_cti_i[j*3 +: 3] = cti;
        bus.m_dat_i[j*32 +: 32] = adr ^ 32'h5A5A_5A5A;
        bus.m_sel_i[j*4 +: 4] = adr[7:4];
        bus.m_we_i[j] = adr[2];
    endtask

    task automatic idle();
        for (int j = 0; j < NM; j++) drv(j, 0, 0, 0);
        bus.s_ack_i = '0;
    endtask

    // Called just after a falling edge with inputs driven; checks, then advances the model one clock.
    task automatic step();
        int slv, nxt;
        bit cyc, stb, fire, sack;
        logic [31:0] a, d;
        logic [7:0] ctl;
        #1;
        a = '0; d = '0; ctl = '0; cyc = 0; stb = 0;
        if (own >= 0) begin
            a = bus.m_adr_i[own*32 +: 32];
            d = bus.m_dat_i[own*32 +: 32];
            ctl = {bus.m_we_i[own], bus.m_sel_i[own*4 +: 4], bus.m_cti_i[own*3 +: 3]};
            cyc = bus.m_cyc_i[own];
            stb = bus.m_stb_i[own];
        end
        slv = (cyc && a[31:29] != 3'd7) ? int'(a[31:29]) : -1;
        sack = slv >= 0 && bus.s_ack_i[slv];
        fire = cnt == TIMEOUT;
        e_ack = (sack && !fire) ? M1 << own : '0;
        e_err = (own >= 0 && (err || fire)) ? M1 << own : '0;
        chk("s_cyc", bus.s_cyc_o, slv >= 0 ? S1 << slv : '0);
        chk("s_stb", bus.s_stb_o, (slv >= 0 && stb && !fire) ? S1 << slv : '0);
        chk("m_ack", bus.m_ack_o, e_ack);
        chk("m_err", bus.m_err_o, e_err);
        chk("m_dat", bus.m_dat_o, slv >= 0 ? bus.s_dat_i[slv*32 +: 32] : 32'h0);
        chk("s_adr", bus.s_adr_o, a);
        chk("s_dat", bus.s_dat_o, d);
        chk("s_ctl", {bus.s_we_o, bus.s_sel_o, bus.s_cti_o}, ctl);
        @(posedge sys_clk);
        if (sys_rst) begin
            own = -1; last = NM - 1; cnt = 0; err = 0;
        end else begin
            err = cyc && stb && a[31:29] == 3'd7 && !err;
            cnt = (cyc && stb && slv >= 0 && !sack && !fire) ? cnt + 1 : 0;
            if (own < 0 || !bus.m_cyc_i[own]) begin
                nxt = -1;
                for (int k = 1; k <= NM; k++)
                    if (nxt < 0 && bus.m_cyc_i[(last + k) % NM]) nxt = (last + k) % NM;
                own = nxt;
                if (nxt >= 0) last = nxt;
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic rst_pulse();
        idle();
        sys_rst = 1;
        step();
        sys_rst = 0;
    endtask

    initial begin
        int rr_exp[5] = '{0, 1, 2, 0, 1};
        int unm_exp[6] = '{0, 0, 1, 0, 1, 0};
        logic [NM-1:0] order[$], up, seen, cy, sb;
        int when[$], beat, t0, t1;
        logic [31:0] ad[NM];
        idle();
        bus.s_dat_i = '0;
        @(negedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        step();
        sys_rst = 0;
        step();

        // single read through slave 2
        bus.s_dat_i[2*32 +: 32] = 32'hDEADBEEF;
        for (int c = 0; c < 6; c++) begin
            drv(0, c < 4, c < 4, 32'h4000_0010);
            bus.s_ack_i = (c == 3) ? 7'b0000100 : 7'b0;
            if (c == 3) begin
                #1;
                chk("rd_dat", bus.m_dat_o, 32'hDEADBEEF);
                chk("rd_ack", bus.m_ack_o, 3'b001);
                chk("rd_cyc", bus.s_cyc_o, 7'b0000100);
            end
            step();
        end

        // round robin, each master drops cyc for one cycle after its ack
        rst_pulse();
        bus.s_ack_i = '1;
        up = '1;
        for (int c = 0; c < 30 && order.size() < 5; c++) begin
            for (int j = 0; j < NM; j++) drv(j, up[j], up[j], {3'(j), 29'h100});
            #1;
            seen = bus.m_ack_o;
            if (|seen) begin
                order.push_back(seen);
                when.push_back(c);
            end
            step();
            up = ~seen;
        end
        chk("rr_n", order.size(), 5);
        for (int k = 0; k < order.size(); k++) begin
            chk("rr_ord", order[k], M1 << rr_exp[k]);
            if (k > 0) chk("rr_gap", when[k] - when[k-1], 2);
        end

        // bus lock during a 4-beat burst by m1
        rst_pulse();
        bus.s_ack_i = '1;
        beat = 0; t0 = -1; t1 = -1;
        for (int c = 0; c < 16; c++) begin
            drv(1, beat < 4, beat < 4, 32'h8000_0000 + 32'(beat * 4), beat == 3 ? EOB : INCR);
            drv(0, beat >= 1, beat >= 1, 32'h0000_0020);
            #1;
            seen = bus.m_ack_o;
            if (seen[1]) begin
                beat++;
                t1 = c;
            end
            if (seen[0] && t0 < 0) t0 = c;
            step();
        end
        chk("lock_beats", beat, 4);
        chk("lock_gap", t0 - t1, 2);

        // unmapped address: one error pulse per beat
        rst_pulse();
        bus.s_ack_i = '1;
        for (int c = 0; c < 6; c++) begin
            drv(2, c < 5, c < 5, 32'hE000_0004);
            #1;
            chk("unm_err", bus.m_err_o, unm_exp[c] != 0 ? 3'b100 : 3'b000);
            chk("unm_cyc", bus.s_cyc_o, 0);
            step();
        end

        // watchdog on slave 5, late ack in the firing cycle
        rst_pulse();
        for (int c = 0; c < 20; c++) begin
            drv(1, c < 19, c < 19, 32'hA000_0000);
            bus.s_ack_i = (c == 17) ? 7'b0100000 : 7'b0;
            #1;
            if (c == 17) begin
                chk("wd_err", bus.m_err_o, 3'b010);
                chk("wd_stb", bus.s_stb_o, 0);
                chk("wd_ack", bus.m_ack_o, 0);
            end else if (c > 0 && c < 19) begin
                chk("wd_quiet", bus.m_err_o, 0);
                chk("wd_live", bus.s_stb_o, 7'b0100000);
            end
            step();
        end

        // reset in the middle of a burst by m1
        rst_pulse();
        for (int c = 0; c < 4; c++) begin
            drv(1, 1, 1, 32'h8000_0000, INCR);
            step();
        end
        drv(0, 1, 1, 32'h0000_0040);
        sys_rst = 1;
        step();
        sys_rst = 0;
        bus.s_ack_i = '1;
        #1;
        chk("rst_cyc", bus.s_cyc_o, 0);
        chk("rst_ack", bus.m_ack_o, 0);
        chk("rst_err", bus.m_err_o, 0);
        step();
        #1;
        chk("rst_first", bus.m_ack_o, 3'b001);
        step();
        rst_pulse();

        // randomized traffic
        cy = '0; sb = '0;
        for (int j = 0; j < NM; j++) ad[j] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < NM; j++) begin
                if (!cy[j]) begin
                    if ($urandom_range(3) == 0) begin
                        cy[j] = 1; sb[j] = 1; ad[j] = $urandom;
                    end
                end else if (e_ack[j] || e_err[j]) begin
                    if ($urandom_range(1) == 0) begin
                        cy[j] = 0; sb[j] = 0;
                    end else begin
                        sb[j] = 1; ad[j] = $urandom;
                    end
                end else if ($urandom_range(29) == 0) sb[j] = ~sb[j];
                drv(j, cy[j], sb[j], ad[j], 3'($urandom_range(7)));
            end
            for (int i = 0; i < NS; i++) begin
                bus.s_ack_i[i] = (i == 5) ? ($urandom_range(39) == 0) : ($urandom_range(2) == 0);
                bus.s_dat_i[i*32 +: 32] = $urandom;
            end
            sys_rst = $urandom_range(299) == 0;
            step();
        end
        sys_rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
